// File: rtl/cmd_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_link_pkg
//  Purpose  : Shared types and constants for the two-byte command link.
//             Holds the sender FSM state type and the frame/command sizing.
//  Revision : 1.0  initial release
// ============================================================================
package cmd_link_pkg;

    // One 8N1 frame: start bit, eight data bits, stop bit.
    localparam int FRAME_BITS = 10;
    // A command is sent as this many bytes, MSB byte first.
    localparam int CMD_BYTES  = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2,
        WAIT_RESP = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_byte
//  Purpose  : 8N1 byte serialiser. A load starts a frame (start bit, data
//             LSB first, stop bit); each bit lasts BAUD_DIV clk cycles.
//             A load is accepted at any time, including the cycle done is
//             high, so frames can be chained back to back with no gap.
//  Ports    : clk   - system clock
//             rst   - synchronous active-high reset
//             load  - start a new frame with data
//             data  - byte to send
//             TX    - serial line, idle high
//             done  - one-cycle pulse in the last cycle of the stop bit
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_byte
    import cmd_link_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       TX,
    output logic       done
);

    localparam logic [15:0] c_BAUD_RELOAD = 16'(BAUD_DIV - 1);
    localparam logic [3:0]  c_LAST_BIT    = 4'(FRAME_BITS - 1);

    logic [8:0]  r_shift;      // remaining data bits followed by the stop bit
    logic [15:0] r_baud_cnt;   // counts down to zero across one bit time
    logic [3:0]  r_bit_cnt;    // index of the bit currently on the line
    logic        r_active;
    logic        r_tx;

    logic w_bit_end;
    logic w_done;

    assign w_bit_end = r_active && (r_baud_cnt == 16'd0);
    assign w_done    = w_bit_end && (r_bit_cnt == c_LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx       <= 1'b1;
            r_active   <= 1'b0;
            r_shift    <= 9'h1FF;
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 4'd0;
        end else if (load) begin
            // Start bit goes on the line immediately.
            r_tx       <= 1'b0;
            r_shift    <= {1'b1, data};
            r_baud_cnt <= c_BAUD_RELOAD;
            r_bit_cnt  <= 4'd0;
            r_active   <= 1'b1;
        end else if (w_done) begin
            r_active   <= 1'b0;
            r_tx       <= 1'b1;
        end else if (w_bit_end) begin
            r_baud_cnt <= c_BAUD_RELOAD;
            r_bit_cnt  <= r_bit_cnt + 4'd1;
            r_tx       <= r_shift[0];
            r_shift    <= {1'b1, r_shift[8:1]};
        end else if (r_active) begin
            r_baud_cnt <= r_baud_cnt - 16'd1;
        end
    end

    assign TX   = r_tx;
    assign done = w_done;

endmodule
`default_nettype wire

// File: rtl/cmd_frame_sender.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_frame_sender
//  Purpose  : Sends a 16-bit command as two 8N1 frames (MSB byte, then LSB
//             byte, no gap) and collects the single response byte from the
//             byte-level UART receiver.
//  Ports    : clk          - system clock
//             rst          - synchronous active-high reset
//             cmd          - command, captured when snd_cmd is accepted
//             snd_cmd      - one-cycle send request (ignored unless idle)
//             busy         - high whenever the FSM is not IDLE
//             cmd_snt      - both frames are complete (held until next send)
//             TX           - serial line, idle high
//             rx_rdy       - receiver holds a byte
//             rx_data      - receiver byte
//             clr_rx_rdy   - one-cycle pulse consuming rx_rdy
//             resp         - latched response byte
//             resp_rdy     - resp valid (held until next send)
//             resp_timeout - response timed out (held until next send)
//  Options  : RESP_TIMEOUT_EN - when defined, WAIT_RESP gives up after
//             TIMEOUT_CYC cycles; otherwise it waits forever and
//             resp_timeout is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module cmd_frame_sender
    import cmd_link_pkg::*;
#(
    parameter int BAUD_DIV    = 2604,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        busy,
    output logic        cmd_snt,
    output logic        TX,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [7:0]  resp,
    output logic        resp_rdy,
    output logic        resp_timeout
);

    if (BAUD_DIV < 4 || BAUD_DIV > 65535) begin : g_bad_baud
        $error("cmd_frame_sender: BAUD_DIV out of range 4..65535");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("cmd_frame_sender: TIMEOUT_CYC must be at least 1");
    end

    state_t r_state;
    state_t w_state_next;

    logic [CMD_BYTES*8-1:0] r_cmd;
    logic                   r_load_msb;   // accept is registered so TX falls one edge later
    logic                   r_cmd_snt;
    logic [7:0]             r_resp;
    logic                   r_resp_rdy;

    logic       w_accept;
    logic       w_take_resp;
    logic       w_clr_rx;
    logic       w_set_snt;
    logic       w_timeout;
    logic       w_tx_load;
    logic [7:0] w_tx_data;
    logic       w_tx_done;

`ifdef RESP_TIMEOUT_EN
    localparam logic [31:0] c_TMO_LAST = 32'(TIMEOUT_CYC - 1);

    logic [31:0] r_tmo_cnt;
    logic        r_resp_timeout;
    logic        w_tmo_hit;

    assign w_tmo_hit = (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt      <= 32'd0;
            r_resp_timeout <= 1'b0;
        end else begin
            // Counts only while waiting; restarts at zero on each entry.
            r_tmo_cnt <= (r_state == WAIT_RESP) ? r_tmo_cnt + 32'd1 : 32'd0;
            if (w_timeout) begin
                r_resp_timeout <= 1'b1;
            end else if (w_accept) begin
                r_resp_timeout <= 1'b0;
            end
        end
    end

    assign resp_timeout = r_resp_timeout;
`else
    assign resp_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_take_resp  = 1'b0;
        w_clr_rx     = 1'b0;
        w_set_snt    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (snd_cmd) begin
                    w_accept     = 1'b1;
                    w_state_next = HIGH;
                end else if (rx_rdy) begin
                    // Nothing outstanding: the byte is stale, drop it.
                    w_clr_rx = 1'b1;
                end
            end
            HIGH: begin
                if (w_tx_done) begin
                    w_state_next = LOW;
                end
            end
            LOW: begin
                if (w_tx_done) begin
                    w_set_snt    = 1'b1;
                    w_state_next = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // A byte that arrived during HIGH/LOW is still pending here.
                if (rx_rdy) begin
                    w_take_resp  = 1'b1;
                    w_clr_rx     = 1'b1;
                    w_state_next = IDLE;
                end
`ifdef RESP_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_timeout    = 1'b1;
                    w_state_next = IDLE;
                end
`endif
            end
            default: w_state_next = IDLE;
        endcase
    end

    // MSB frame is launched from the registered accept; the LSB frame is
    // loaded on the MSB frame's done cycle so it follows with no idle gap.
    assign w_tx_load = r_load_msb || ((r_state == HIGH) && w_tx_done);
    assign w_tx_data = r_load_msb ? r_cmd[15:8] : r_cmd[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd      <= '0;
            r_load_msb <= 1'b0;
            r_cmd_snt  <= 1'b0;
            r_resp     <= 8'h00;
            r_resp_rdy <= 1'b0;
        end else begin
            r_load_msb <= w_accept;
            if (w_accept) begin
                r_cmd <= cmd;
            end
            if (w_set_snt) begin
                r_cmd_snt <= 1'b1;
            end else if (w_accept) begin
                r_cmd_snt <= 1'b0;
            end
            if (w_take_resp) begin
                r_resp     <= rx_data;
                r_resp_rdy <= 1'b1;
            end else if (w_accept) begin
                r_resp_rdy <= 1'b0;
            end
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .load (w_tx_load),
        .data (w_tx_data),
        .TX   (TX),
        .done (w_tx_done)
    );

    assign busy       = (r_state != IDLE);
    assign cmd_snt    = r_cmd_snt;
    assign resp       = r_resp;
    assign resp_rdy   = r_resp_rdy;
    // The FSM sits in IDLE while reset is held; keep the strobe quiet then.
    assign clr_rx_rdy = w_clr_rx && !rst;

endmodule
`default_nettype wire

// File: tb/tb_cmd_frame_sender.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmd_frame_sender
//  Purpose  : Self-checking bench for cmd_frame_sender (BAUD_DIV=4,
//             TIMEOUT_CYC=50). Expected line activity is derived from the
//             frame format (start, 8 data LSB first, stop; 20 bits back to
//             back starting one edge after accept). Build with or without
//             RESP_TIMEOUT_EN to match the RTL.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cmd_frame_sender;

    localparam int BAUD_DIV    = 4;
    localparam int TIMEOUT_CYC = 50;
    localparam int FRAME       = 10;
    localparam int SNT_T       = 2 * FRAME * BAUD_DIV + 1;   // edge where cmd_snt rises

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cmd = 16'h0;
    logic        snd_cmd = 1'b0;
    logic        busy;
    logic        cmd_snt;
    logic        TX;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        clr_rx_rdy;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        resp_timeout;

    int n_checks = 0;
    int n_err    = 0;
    int clr_cnt  = 0;

    logic  tx_hist [0:255];
    int    nbad   [5];
    int    nfirst [5];
    logic  ngot   [5];
    logic  nwant  [5];
    string nname  [5] = '{"tx", "busy", "cmd_snt", "resp_rdy", "resp_timeout"};

    typedef struct {
        string       tag;
        logic [15:0] cmd;
        int          rx_at;
        logic [7:0]  rb;
        int          ign_at;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;
    vec_t vecs [5];

    cmd_frame_sender #(
        .BAUD_DIV    (BAUD_DIV),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cmd),
        .snd_cmd      (snd_cmd),
        .busy         (busy),
        .cmd_snt      (cmd_snt),
        .TX           (TX),
        .rx_rdy       (rx_rdy),
        .rx_data      (rx_data),
        .clr_rx_rdy   (clr_rx_rdy),
        .resp         (resp),
        .resp_rdy     (resp_rdy),
        .resp_timeout (resp_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Expected line level t edges after the accept edge.
    function automatic logic model_tx(input logic [15:0] c, input int t);
        int         k;
        int         b;
        logic [7:0] byt;
        if (t < 1 || t >= SNT_T) return 1'b1;
        k   = (t - 1) / BAUD_DIV;
        b   = k % FRAME;
        byt = (k < FRAME) ? c[15:8] : c[7:0];
        if (b == 0) return 1'b0;
        if (b == FRAME - 1) return 1'b1;
        return byt[b-1];
    endfunction

    // One clock: read the strobe mid-cycle, then act as the receiver that
    // drops rx_rdy after a consuming edge.
    task automatic cyc();
        logic c;
        @(negedge clk);
        c = clr_rx_rdy;
        @(posedge clk);
        #1;
        if (c) begin
            clr_cnt++;
            rx_rdy = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic clear_notes();
        for (int s = 0; s < 5; s++) begin
            nbad[s] = 0;
            nfirst[s] = 0;
        end
    endtask

    task automatic note(input int s, input int t, input logic got, input logic want);
        if (got !== want) begin
            if (nbad[s] == 0) begin
                nfirst[s] = t;
                ngot[s]   = got;
                nwant[s]  = want;
            end
            nbad[s]++;
        end
    endtask

    task automatic report_notes(input string tag);
        for (int s = 0; s < 5; s++) begin
            n_checks++;
            if (nbad[s] != 0) begin
                n_err++;
                $display("FAIL %s %s: %0d wrong cycles, first at t=%0d got %b want %b",
                         tag, nname[s], nbad[s], nfirst[s], ngot[s], nwant[s]);
            end
        end
    endtask

    task automatic run_cmd(input string tag, input logic [15:0] c, input int rx_at,
                           input logic [7:0] rb, input int ign_at,
                           input logic [7:0] want_hi, input logic [7:0] want_lo);
        int         done_t;
        int         frame_err;
        int         ts;
        logic [7:0] dec [2];
        clear_notes();
        rx_rdy  = 1'b0;
        clr_cnt = 0;
        done_t  = ((rx_at > SNT_T) ? rx_at : SNT_T) + 1;
        cmd     = c;
        snd_cmd = 1'b1;
        cyc();
        snd_cmd = 1'b0;
        cmd     = ~c;
        for (int t = 0; t <= done_t + 1; t++) begin
            tx_hist[t] = TX;
            note(0, t, TX, model_tx(c, t));
            note(1, t, busy, t < done_t);
            note(2, t, cmd_snt, t >= SNT_T);
            note(3, t, resp_rdy, t >= done_t);
            note(4, t, resp_timeout, 1'b0);
            snd_cmd = 1'b0;
            if (t == rx_at) begin
                rx_rdy  = 1'b1;
                rx_data = rb;
            end
            if (t == ign_at) begin
                snd_cmd = 1'b1;
                cmd     = 16'hFFFF;
            end
            if (t <= done_t) cyc();
        end
        snd_cmd = 1'b0;
        report_notes(tag);
        // Decode the line at mid-bit like a UART receiver would.
        frame_err = 0;
        dec[0] = 8'h00;
        dec[1] = 8'h00;
        for (int k = 0; k < 2 * FRAME; k++) begin
            ts = 1 + k * BAUD_DIV + BAUD_DIV / 2;
            if (k % FRAME == 0) begin
                if (tx_hist[ts] !== 1'b0) frame_err++;
            end else if (k % FRAME == FRAME - 1) begin
                if (tx_hist[ts] !== 1'b1) frame_err++;
            end else begin
                dec[k / FRAME][(k % FRAME) - 1] = tx_hist[ts];
            end
        end
        chk({tag, " framing errors"}, 32'(frame_err), 32'd0);
        chk({tag, " msb byte"}, {24'h0, dec[0]}, {24'h0, want_hi});
        chk({tag, " lsb byte"}, {24'h0, dec[1]}, {24'h0, want_lo});
        chk({tag, " resp"}, {24'h0, resp}, {24'h0, rb});
        chk({tag, " clr pulses"}, 32'(clr_cnt), 32'd1);
    endtask

    initial begin
        logic [15:0] rc;
        int          rx_at;
        int          ign_at;
        logic [7:0]  rb;
        logic        exp_busy;
        logic        exp_flag;

        vecs[0] = '{"basic",        16'hA53C,  85, 8'h5A, -1, 8'hA5, 8'h3C};
        vecs[1] = '{"ignored_req",  16'hA53C,  90, 8'hC3, 30, 8'hA5, 8'h3C};
        vecs[2] = '{"pending_lsb",  16'h1E2D,  60, 8'h77, -1, 8'h1E, 8'h2D};
        vecs[3] = '{"rx_at_expiry", 16'h0000, 130, 8'hFF, -1, 8'h00, 8'h00};
        vecs[4] = '{"rx_at_entry",  16'hFFFF,  81, 8'h00, 80, 8'hFF, 8'hFF};

        // Reset state
        rst = 1'b1;
        cyc();
        cyc();
        chk("reset TX", {31'h0, TX}, 32'd1);
        chk("reset busy", {31'h0, busy}, 32'd0);
        chk("reset cmd_snt", {31'h0, cmd_snt}, 32'd0);
        chk("reset resp", {24'h0, resp}, 32'h00);
        chk("reset resp_rdy", {31'h0, resp_rdy}, 32'd0);
        chk("reset clr_rx_rdy", {31'h0, clr_rx_rdy}, 32'd0);
        chk("reset resp_timeout", {31'h0, resp_timeout}, 32'd0);
        rst = 1'b0;
        cyc();

        for (int i = 0; i < 5; i++) begin
            run_cmd(vecs[i].tag, vecs[i].cmd, vecs[i].rx_at, vecs[i].rb,
                    vecs[i].ign_at, vecs[i].hi, vecs[i].lo);
            cyc();
        end

        // Stale byte while idle: consumed, response untouched.
        clr_cnt = 0;
        rx_rdy  = 1'b1;
        rx_data = 8'h77;
        cyc();
        cyc();
        chk("stale clr pulses", 32'(clr_cnt), 32'd1);
        chk("stale rx_rdy dropped", {31'h0, rx_rdy}, 32'd0);
        chk("stale resp", {24'h0, resp}, 32'h00);
        chk("stale resp_rdy", {31'h0, resp_rdy}, 32'd1);
        chk("stale busy", {31'h0, busy}, 32'd0);

        // Reset in the middle of the MSB frame.
        cmd     = 16'h1234;
        snd_cmd = 1'b1;
        cyc();
        snd_cmd = 1'b0;
        for (int i = 0; i < 25; i++) cyc();
        chk("midframe TX", {31'h0, TX}, {31'h0, model_tx(16'h1234, 25)});
        rst = 1'b1;
        cyc();
        chk("midrst TX", {31'h0, TX}, 32'd1);
        chk("midrst busy", {31'h0, busy}, 32'd0);
        chk("midrst cmd_snt", {31'h0, cmd_snt}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        chk("post-rst TX idle", {31'h0, TX}, 32'd1);
        run_cmd("after_reset", 16'h1234, 95, 8'h42, -1, 8'h12, 8'h34);
        cyc();

        // No response at all.
        clear_notes();
        clr_cnt = 0;
        cmd     = 16'hC0DE;
        snd_cmd = 1'b1;
        cyc();
        snd_cmd = 1'b0;
        for (int t = 0; t <= 140; t++) begin
`ifdef RESP_TIMEOUT_EN
            exp_flag = (t >= SNT_T + TIMEOUT_CYC);
            exp_busy = (t <  SNT_T + TIMEOUT_CYC);
`else
            exp_flag = 1'b0;
            exp_busy = 1'b1;
`endif
            note(0, t, TX, model_tx(16'hC0DE, t));
            note(1, t, busy, exp_busy);
            note(2, t, cmd_snt, t >= SNT_T);
            note(3, t, resp_rdy, 1'b0);
            note(4, t, resp_timeout, exp_flag);
            if (t < 140) cyc();
        end
        report_notes("no_response");
        chk("no_response clr pulses", 32'(clr_cnt), 32'd0);
`ifndef RESP_TIMEOUT_EN
        rx_rdy  = 1'b1;
        rx_data = 8'h99;
        cyc();
        cyc();
        chk("late resp", {24'h0, resp}, 32'h99);
        chk("late resp_rdy", {31'h0, resp_rdy}, 32'd1);
        chk("late busy", {31'h0, busy}, 32'd0);
`endif
        run_cmd("after_no_response", 16'h5AA5, 100, 8'h3E, -1, 8'h5A, 8'hA5);
        cyc();

        // Randomised commands, response timing and ignored requests.
        for (int i = 0; i < 8; i++) begin
            rc     = 16'($urandom);
            rb     = 8'($urandom);
            rx_at  = int'($urandom_range(0, 125));
            ign_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 80)) : -1;
            run_cmd($sformatf("random%0d", i), rc, rx_at, rb, ign_at, rc[15:8], rc[7:0]);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
